mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mau_pkg.sv | 41 ++++
 rtl/mau_lane_align.sv | 59 +++++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared constants, op codes and FSM state type for the memory access unit.
package mau_pkg;

    localparam int IDX_W   = 8;
    localparam int DATA_W  = 32;
    localparam int RDEST_W = 5;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LB  = 4'h1;
    localparam logic [3:0] OP_LBU = 4'h2;
    localparam logic [3:0] OP_LH  = 4'h3;
    localparam logic [3:0] OP_LHU = 4'h4;
    localparam logic [3:0] OP_LW  = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h6;
    localparam logic [3:0] OP_SH  = 4'h7;
    localparam logic [3:0] OP_SW  = 4'h8;

    typedef enum logic {
        ST_IDLE,
        ST_MERGE_WR
    } mau_state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    // Byte and halfword stores need a read-modify-write of the containing word.
    function automatic logic is_sub_word_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] offset);
        logic half_op;
        logic word_op;
        half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word_op = (op == OP_LW) || (op == OP_SW);
        return (half_op && offset[0]) || (word_op && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Big-endian lane extraction/extension for loads and lane merging for SB/SH.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] rword,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_value,
    output logic [DATA_W-1:0] merged_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[DATA_W-1:16];

    always_comb begin
        sel_byte = rword[31:24];
        case (offset)
            2'd0: sel_byte = rword[31:24];
            2'd1: sel_byte = rword[23:16];
            2'd2: sel_byte = rword[15:8];
            2'd3: sel_byte = rword[7:0];
            default: sel_byte = rword[31:24];
        endcase
        sel_half = offset[1] ? rword[15:0] : rword[31:16];

        load_value = '0;
        case (op)
            OP_LB:   load_value = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_value = {24'h0, sel_byte};
            OP_LH:   load_value = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_value = {16'h0, sel_half};
            OP_LW:   load_value = rword;
            default: load_value = '0;
        endcase
    end

    // Lane gi sits at bits [31-8*gi -: 8]; a halfword covers lanes {0,1} or {2,3}.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam int         HI   = DATA_W - 1 - 8 * gi;
        localparam logic [1:0] LANE = 2'(gi);
        logic [7:0] wr_byte;

        always_comb begin
            wr_byte = rword[HI -: 8];
            if (op == OP_SB && offset == LANE) begin
                wr_byte = wdata[7:0];
            end else if (op == OP_SH && offset[1] == LANE[1]) begin
                wr_byte = LANE[0] ? wdata[7:0] : wdata[15:8];
            end
        end

        assign merged_word[HI -: 8] = wr_byte;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-addressed data memory; SB/SH go through
// a one-word merge buffer and a second write cycle.
module mem_access_unit
    import mau_pkg::*;
(
    input  logic        MAU_clk,
    input  logic        MAU_rst,
    input  logic        MAU_req_valid,
    output logic        MAU_req_ready,
    input  logic [3:0]  MAU_op,
    input  logic [31:0] MAU_addr,
    input  logic [31:0] MAU_wdata,
    input  logic [4:0]  MAU_rdest,
    output logic [31:0] MAU_rdata,
    output logic        MAU_rdata_valid,
    output logic [4:0]  MAU_rdest_out,
    output logic        MAU_misaligned,
    output logic [7:0]  MAU_dmem_address,
    output logic [31:0] MAU_dmem_data_in,
    output logic        MAU_dmem_mem_write,
    output logic        MAU_dmem_mem_read,
    input  logic [31:0] MAU_dmem_data_out
);

    mau_state_e state_reg, state_next;

    logic [DATA_W-1:0]  rdata_reg;
    logic               rdata_valid_reg;
    logic [RDEST_W-1:0] rdest_reg;
    logic               misaligned_reg;
    logic [DATA_W-1:0]  merge_word_reg;
    logic [IDX_W-1:0]   merge_idx_reg;

    logic [IDX_W-1:0]   req_idx;
    logic [1:0]         req_offset;
    logic [DATA_W-1:0]  load_value;
    logic [DATA_W-1:0]  merged_word;
    logic               load_go;
    logic               merge_go;
    logic               fault_go;
    logic               req_ready;
    logic               mem_read;
    logic               mem_write;
    logic [IDX_W-1:0]   dmem_address;
    logic [DATA_W-1:0]  dmem_data_in;
    logic               unused_addr_bits;

    assign req_idx          = MAU_addr[IDX_W+1:2];
    assign req_offset       = MAU_addr[1:0];
    assign unused_addr_bits = ^MAU_addr[31:IDX_W+2];

    mau_lane_align u_lane_align (
        .op          (MAU_op),
        .offset      (req_offset),
        .rword       (MAU_dmem_data_out),
        .wdata       (MAU_wdata),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    // Reset gates every strobe here, so an in-flight merge write is dropped.
    always_comb begin
        state_next   = state_reg;
        req_ready    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        dmem_address = req_idx;
        dmem_data_in = MAU_wdata;
        load_go      = 1'b0;
        merge_go     = 1'b0;
        fault_go     = 1'b0;
        if (!MAU_rst) begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready = 1'b1;
                    if (MAU_req_valid) begin
                        if (is_misaligned(MAU_op, req_offset)) begin
                            fault_go = 1'b1;
                        end else if (is_load(MAU_op)) begin
                            mem_read = 1'b1;
                            load_go  = 1'b1;
                        end else if (MAU_op == OP_SW) begin
                            mem_write = 1'b1;
                        end else if (is_sub_word_store(MAU_op)) begin
                            mem_read   = 1'b1;
                            merge_go   = 1'b1;
                            state_next = ST_MERGE_WR;
                        end
                    end
                end
                ST_MERGE_WR: begin
                    mem_write    = 1'b1;
                    dmem_address = merge_idx_reg;
                    dmem_data_in = merge_word_reg;
                    state_next   = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge MAU_clk) begin
        if (MAU_rst) begin
            state_reg       <= ST_IDLE;
            rdata_reg       <= '0;
            rdata_valid_reg <= 1'b0;
            rdest_reg       <= '0;
            misaligned_reg  <= 1'b0;
            merge_word_reg  <= '0;
            merge_idx_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            rdata_valid_reg <= load_go;
            misaligned_reg  <= fault_go;
            if (load_go) begin
                rdata_reg <= load_value;
                rdest_reg <= MAU_rdest;
            end
            if (merge_go) begin
                merge_word_reg <= merged_word;
                merge_idx_reg  <= req_idx;
            end
        end
    end

    assign MAU_req_ready      = req_ready;
    assign MAU_rdata          = rdata_reg;
    assign MAU_rdata_valid    = rdata_valid_reg;
    assign MAU_rdest_out      = rdest_reg;
    assign MAU_misaligned     = misaligned_reg;
    assign MAU_dmem_address   = dmem_address;
    assign MAU_dmem_data_in   = dmem_data_in;
    assign MAU_dmem_mem_write = mem_write;
    assign MAU_dmem_mem_read  = mem_read;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios then random traffic against a
// byte-arithmetic model of a 256-word big-endian memory.
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  op = 4'h0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rdest = '0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [4:0]  rdest_out;
    logic        misaligned;
    logic [7:0]  dmem_address;
    logic [31:0] dmem_data_in;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] dmem_data_out;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    logic [31:0] dmem    [256];
    logic [31:0] ref_mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .MAU_clk            (clk),
        .MAU_rst            (rst),
        .MAU_req_valid      (req_valid),
        .MAU_req_ready      (req_ready),
        .MAU_op             (op),
        .MAU_addr           (addr),
        .MAU_wdata          (wdata),
        .MAU_rdest          (rdest),
        .MAU_rdata          (rdata),
        .MAU_rdata_valid    (rdata_valid),
        .MAU_rdest_out      (rdest_out),
        .MAU_misaligned     (misaligned),
        .MAU_dmem_address   (dmem_address),
        .MAU_dmem_data_in   (dmem_data_in),
        .MAU_dmem_mem_write (mem_write),
        .MAU_dmem_mem_read  (mem_read),
        .MAU_dmem_data_out  (dmem_data_out)
    );

    always @(posedge clk) begin
        if (pre_we) dmem[pre_idx] <= pre_data;
        else if (mem_write) dmem[dmem_address] <= dmem_data_in;
    end
    assign dmem_data_out = dmem[dmem_address];

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) check32("rd_wr_exclusive", {31'h0, mem_read & mem_write}, 32'h0);

    function automatic logic [31:0] model_load(input logic [3:0] o_op, input logic [31:0] word, input int off);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (24 - 8 * off)) & 32'hFF;
        h = (word >> (16 - 8 * off)) & 32'hFFFF;
        case (o_op)
            OP_LB:   return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            OP_LHU:  return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [3:0] o_op, input logic [31:0] word,
                                                input logic [31:0] wd, input int off);
        logic [31:0] mask;
        int sh;
        if (o_op == OP_SB) begin
            sh = 24 - 8 * off;
            mask = 32'hFF << sh;
        end else begin
            sh = 16 - 8 * off;
            mask = 32'hFFFF << sh;
        end
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    function automatic string op_name(input logic [3:0] o_op);
        case (o_op)
            OP_LB: return "LB";   OP_LBU: return "LBU";
            OP_LH: return "LH";   OP_LHU: return "LHU";
            OP_LW: return "LW";   OP_SB:  return "SB";
            OP_SH: return "SH";   OP_SW:  return "SW";
            default: return "NOP";
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the op completes.
    task automatic do_txn(input logic [3:0] t_op, input logic [31:0] t_addr,
                          input logic [31:0] t_wdata, input logic [4:0] t_rdest);
        bit is_ld, is_sw, is_rmw, bad;
        int idx, off;
        logic [31:0] exp_ld, exp_word;
        idx    = int'(t_addr[9:2]);
        off    = int'(t_addr[1:0]);
        is_ld  = (t_op == OP_LB) || (t_op == OP_LBU) || (t_op == OP_LH) ||
                 (t_op == OP_LHU) || (t_op == OP_LW);
        is_sw  = (t_op == OP_SW);
        is_rmw = (t_op == OP_SB) || (t_op == OP_SH);
        bad    = (((t_op == OP_LH) || (t_op == OP_LHU) || (t_op == OP_SH)) && (off % 2 != 0)) ||
                 (((t_op == OP_LW) || (t_op == OP_SW)) && (off != 0));
        exp_ld = model_load(t_op, ref_mem[idx], off);

        req_valid = 1'b1; op = t_op; addr = t_addr; wdata = t_wdata; rdest = t_rdest;
        #1;
        check32("ready_idle", {31'h0, req_ready}, 32'h1);
        check32("mem_read", {31'h0, mem_read}, {31'h0, (is_ld || is_rmw) && !bad});
        check32("mem_write", {31'h0, mem_write}, {31'h0, is_sw && !bad});
        if ((is_ld || is_sw || is_rmw) && !bad)
            check32("dmem_address", {24'h0, dmem_address}, idx);
        if (is_sw && !bad)
            check32("sw_data_in", dmem_data_in, t_wdata);

        @(posedge clk); #1;
        req_valid = 1'b0; op = OP_NOP;
        if (is_sw && !bad) ref_mem[idx] = t_wdata;
        check32("rdata_valid", {31'h0, rdata_valid}, {31'h0, is_ld && !bad});
        check32("misaligned", {31'h0, misaligned}, {31'h0, bad});
        if (is_ld && !bad) begin
            check32("rdata", rdata, exp_ld);
            check32("rdest_out", {27'h0, rdest_out}, {27'h0, t_rdest});
            last_rdata = exp_ld;
        end else begin
            check32("rdata_hold", rdata, last_rdata);
        end

        if (is_rmw && !bad) begin
            exp_word = model_store(t_op, ref_mem[idx], t_wdata, off);
            check32("merge_ready", {31'h0, req_ready}, 32'h0);
            check32("merge_write", {31'h0, mem_write}, 32'h1);
            check32("merge_read", {31'h0, mem_read}, 32'h0);
            check32("merge_address", {24'h0, dmem_address}, idx);
            check32("merge_data_in", dmem_data_in, exp_word);
            ref_mem[idx] = exp_word;
            @(posedge clk); #1;
            check32("merge_no_strobe", {30'h0, rdata_valid, misaligned}, 32'h0);
        end
        txn_no++;
        $display("txn %0d op=%s addr=%h wdata=%h rdest=%0d rdata=%h valid=%0d fault=%0d",
                 txn_no, op_name(t_op), t_addr, t_wdata, t_rdest, rdata, rdata_valid, misaligned);
    endtask

    logic [3:0] op_tbl [10];
    logic [31:0] saved_word;

    initial begin
        op_tbl = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_NOP, 4'hB};
        last_rdata = '0;

        // Preload memory while reset holds the unit quiet.
        @(posedge clk); #1;
        pre_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pre_idx  = 8'(i);
            pre_data = (i == 5) ? 32'h80FF_1234 : $urandom;
            ref_mem[i] = pre_data;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;

        // Request during reset: no access, not ready.
        req_valid = 1'b1; op = OP_SW; addr = 32'h0000_0004; wdata = 32'h1111_1111;
        #1;
        check32("rst_ready", {31'h0, req_ready}, 32'h0);
        check32("rst_write", {31'h0, mem_write}, 32'h0);
        check32("rst_read", {31'h0, mem_read}, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0; op = OP_NOP;
        rst = 1'b0;
        #1;
        check32("reset_outputs", {rdata_valid, misaligned, rdest_out, 25'h0}, 32'h0);
        check32("reset_rdata", rdata, 32'h0);
        check32("reset_ready", {31'h0, req_ready}, 32'h1);

        // Sign/zero extension of byte lanes.
        do_txn(OP_LB, 32'h0000_0014, 32'h0, 5'd3);
        check32("lb_0x14", rdata, 32'hFFFF_FF80);
        do_txn(OP_LBU, 32'h0000_0015, 32'h0, 5'd4);
        check32("lbu_0x15", rdata, 32'h0000_00FF);

        // Halfword merge then immediate read-back.
        do_txn(OP_SH, 32'h0000_0016, 32'h0000_ABCD, 5'd0);
        check32("sh_mem_word", dmem[5], 32'h80FF_ABCD);
        do_txn(OP_LW, 32'h0000_0014, 32'h0, 5'd9);
        check32("lw_after_sh", rdata, 32'h80FF_ABCD);

        // Address wrap at 1 KiB.
        do_txn(OP_SW, 32'h0000_0400, 32'hDEAD_BEEF, 5'd0);
        check32("sw_wrap_mem", dmem[0], 32'hDEAD_BEEF);
        check32("sw_ready_kept", {31'h0, req_ready}, 32'h1);

        // Misaligned accesses.
        do_txn(OP_LW, 32'h0000_0013, 32'h0, 5'd7);
        do_txn(OP_LHU, 32'h0000_0013, 32'h0, 5'd8);
        do_txn(OP_SW, 32'h0000_0022, 32'h1234_5678, 5'd0);

        // Back-to-back mix.
        do_txn(OP_LW, 32'h0000_0020, 32'h0, 5'd1);
        do_txn(OP_SB, 32'h0000_0021, 32'h0000_00A5, 5'd0);
        do_txn(OP_LH, 32'h0000_0022, 32'h0, 5'd2);
        do_txn(OP_LB, 32'h0000_0021, 32'h0, 5'd3);
        do_txn(OP_SB, 32'h0000_0027, 32'h0000_007F, 5'd0);
        do_txn(OP_LW, 32'h0000_0024, 32'h0, 5'd31);

        // Reset during MERGE_WR aborts the write.
        saved_word = dmem[8];
        req_valid = 1'b1; op = OP_SB; addr = 32'h0000_0020; wdata = 32'h0000_0055;
        @(posedge clk); #1;
        req_valid = 1'b0; op = OP_NOP;
        rst = 1'b1;
        #1;
        check32("abort_write", {31'h0, mem_write}, 32'h0);
        check32("abort_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check32("abort_mem_kept", dmem[8], saved_word);
        check32("abort_outputs", {rdata_valid, misaligned, rdest_out, 25'h0}, 32'h0);
        check32("abort_rdata", rdata, 32'h0);
        check32("abort_idle", {31'h0, req_ready}, 32'h1);
        last_rdata = '0;

        // Random traffic concentrated on a few words to exercise hazards.
        for (int n = 0; n < 300; n++) begin
            logic [3:0]  r_op;
            logic [31:0] r_addr;
            r_op   = op_tbl[$urandom_range(0, 9)];
            r_addr = ($urandom_range(0, 7) == 0) ? $urandom
                                                 : (($urandom & 32'hFFFF_FC00) | $urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (r_op == OP_LH || r_op == OP_LHU || r_op == OP_SH) r_addr[0] = 1'b0;
                if (r_op == OP_LW || r_op == OP_SW) r_addr[1:0] = 2'b00;
            end
            do_txn(r_op, r_addr, $urandom, 5'($urandom_range(0, 31)));
        end

        for (int i = 0; i < 256; i++) check32("final_mem", dmem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
